pkt_prio_sched: RTL and testbench
=================================

Name: pkt_prio_sched

Overview:
- Downstream stage of the packet prioriser. Accepts its priority-tagged output (data + priority, no backpressure) and buffers words in per-priority circular queues.
- Drains the queues to the egress interface by strict priority under a valid/ready handshake.
- Counts words lost to full queues or illegal priorities, since the upstream stage cannot be stalled.

Parameters:
- DWIDTH, 32, data word width.
- PRIOR_WIDTH, 6, width of incoming priority tag.
- NUM_Q, 8, number of priority queues; queue k holds priority k; legal priorities 1..NUM_Q-1; queue 0 unused.
- Q_DEPTH, 4, entries per queue; power of two, >=2.
- CNT_WIDTH, 16, width of drop/error counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset; sampled on clk rising edge, asserted when 0.
- in_valid  in  1  input word present, from prioriser out_valid.
- in_data  in  DWIDTH  input word.
- in_prior  in  PRIOR_WIDTH  input priority tag.
- out_valid  out  1  egress word valid.
- out_ready  in  1  egress consumer accepts word.
- out_data  out  DWIDTH  egress word.
- out_prior  out  PRIOR_WIDTH  priority the egress word was queued under.
- q_nonempty  out  NUM_Q  bit k = queue k holds >=1 entry; bit 0 always 0.
- drop_cnt  out  CNT_WIDTH  words dropped because target queue full.
- bad_prio_cnt  out  CNT_WIDTH  words dropped because in_prior==0 or >=NUM_Q.

Behaviour:
- Reset (rst==0 at edge): all queue pointers/counts 0, out_valid=0, out_data=0, out_prior=0, q_nonempty=0, drop_cnt=0, bad_prio_cnt=0. Reset mid-operation discards all buffered words; no partial output.
- Per queue: wr_ptr, rd_ptr (log2(Q_DEPTH) bits, wrap modulo Q_DEPTH), count (0..Q_DEPTH). Full = count==Q_DEPTH, empty = count==0.
- Enqueue: on in_valid, legal priority p, queue p not full → write at wr_ptr[p], wr_ptr+1, count+1. Full → word discarded, drop_cnt+1. Illegal priority → discarded, bad_prio_cnt+1. Both counters saturate at all-ones, never wrap.
- Fullness is evaluated before this cycle's dequeue: a full queue drops the incoming word even if it is dequeued in the same cycle.
- Output register: load_en = !out_valid || out_ready.
- On load_en, select the lowest-index non-empty queue k (1 = highest priority) using pre-edge counts. Pop it into out_data/out_prior=k, out_valid=1.
- If load_en and all queues empty: out_valid←0; out_data/out_prior hold.
- While out_valid && !out_ready: out_data/out_prior/out_valid stable; no pop.
- Same-queue enqueue and dequeue in one cycle: both occur, count unchanged. A word enqueued in cycle N is not eligible for pop until N+1.
- Latency: input in cycle N into empty system with out_ready=1 → out_valid high in cycle N+2 (visible after second rising edge).
- Throughput: one pop per cycle when out_ready held high.
- Order: FIFO within a queue; no ordering guarantee across queues.
- q_nonempty reflects registered counts (post-edge).

Optional Feature:
- Macro PRIO_SCHED_STARVE_GUARD_EN.
- With macro: add parameter STARVE_LIMIT (default 8) and a starve counter counting consecutive pops from a queue while any higher-index queue is non-empty. When the counter reaches STARVE_LIMIT, the next pop takes the highest-index non-empty queue. The counter resets to 0 on that pop, on any pop with no higher-index queue waiting, and on reset.
- Without macro: pure strict priority; no counter logic synthesised.

Test Plan:
- Reset then idle → out_valid=0, counters 0, q_nonempty=0. Assert rst=0 mid-traffic with queues 2 and 5 holding words → next cycle all empty, out_valid=0.
- Single word data=0xA5, prior=3, out_ready=1, in cycle 0 → out_valid=1, out_data=0xA5, out_prior=3 in cycle 2; q_nonempty[3] pulses high for one cycle.
- Hold out_ready=0; send words to prio 5 then prio 2 → first output is prio 5 word (already loaded), held stable. After out_ready=1, prio 2 word, then nothing.
- Q_DEPTH=4, out_ready=0: send 6 words prio 4 (first one loads into output register) → 5 buffered-or-output, drop_cnt=1. Send prio 0 and prio 8 → bad_prio_cnt=2.
- Fill queues 1 and 6 continuously, out_ready=1: without macro only queue 1 is served. With PRIO_SCHED_STARVE_GUARD_EN, STARVE_LIMIT=8 → every 9th pop has out_prior=6.
- Wrap test: 10 words data 0..9 to prio 2, out_ready toggling 1/0 → output order 0..9 exactly, drop_cnt=0.

Source files
------------

// File: rtl/pkt_prio_sched.sv
// Strict-priority packet scheduler: per-priority circular queues drained to a valid/ready egress.
// Optional starvation guard enabled by defining PRIO_SCHED_STARVE_GUARD_EN.
module pkt_prio_sched #(
  parameter int DWIDTH       = 32,
  parameter int PRIOR_WIDTH  = 6,
  parameter int NUM_Q        = 8,
  parameter int Q_DEPTH      = 4,
`ifdef PRIO_SCHED_STARVE_GUARD_EN
  parameter int STARVE_LIMIT = 8,
`endif
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DWIDTH-1:0]      in_data,
  input  logic [PRIOR_WIDTH-1:0] in_prior,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DWIDTH-1:0]      out_data,
  output logic [PRIOR_WIDTH-1:0] out_prior,
  output logic [NUM_Q-1:0]       q_nonempty,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  output logic [CNT_WIDTH-1:0]   bad_prio_cnt
);

  localparam int QW = $clog2(NUM_Q);
  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(Q_DEPTH);

  logic [DWIDTH-1:0]      mem_q [NUM_Q][Q_DEPTH];
  logic [PW-1:0]          wr_ptr_q [NUM_Q];
  logic [PW-1:0]          wr_ptr_d [NUM_Q];
  logic [PW-1:0]          rd_ptr_q [NUM_Q];
  logic [PW-1:0]          rd_ptr_d [NUM_Q];
  logic [CW-1:0]          count_q  [NUM_Q];
  logic [CW-1:0]          count_d  [NUM_Q];
  logic                   out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]      out_data_q, out_data_d;
  logic [PRIOR_WIDTH-1:0] out_prior_q, out_prior_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic [CNT_WIDTH-1:0]   bad_q, bad_d;

  logic                   legal, enq_full, enq_ok, load_en, any_ne, pop;
  logic [QW-1:0]          in_idx, lo_idx, pop_idx;
  logic [NUM_Q-1:0]       enq_vec, deq_vec;

`ifdef PRIO_SCHED_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [QW-1:0] hi_idx;
  logic [SW-1:0] starve_q, starve_d;
`endif

  // Selection uses pre-edge counts so a word written this cycle cannot be popped until the next.
  always_comb begin
    legal    = (in_prior != '0) && (in_prior < PRIOR_WIDTH'(NUM_Q));
    in_idx   = in_prior[QW-1:0];
    enq_full = (count_q[in_idx] == FULL);
    enq_ok   = in_valid && legal && !enq_full;
    any_ne   = 1'b0;
    lo_idx   = '0;
    for (int k = NUM_Q - 1; k >= 1; k--) begin
      if (count_q[k] != '0) begin
        any_ne = 1'b1;
        lo_idx = QW'(k);
      end
    end
    load_en = !out_valid_q || out_ready;
    pop     = load_en && any_ne;
`ifdef PRIO_SCHED_STARVE_GUARD_EN
    hi_idx = '0;
    for (int k = 1; k < NUM_Q; k++) begin
      if (count_q[k] != '0) hi_idx = QW'(k);
    end
    pop_idx  = (starve_q >= SW'(STARVE_LIMIT)) ? hi_idx : lo_idx;
    starve_d = starve_q;
    if (pop) starve_d = (pop_idx == hi_idx) ? '0 : starve_q + SW'(1);
`else
    pop_idx = lo_idx;
`endif
    enq_vec = enq_ok ? (NUM_Q'(1) << in_idx) : '0;
    deq_vec = pop ? (NUM_Q'(1) << pop_idx) : '0;
  end

  always_comb begin
    for (int k = 0; k < NUM_Q; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      count_d[k]  = count_q[k];
      if (enq_vec[k]) wr_ptr_d[k] = wr_ptr_q[k] + PW'(1);
      if (deq_vec[k]) rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
      if (enq_vec[k] && !deq_vec[k]) count_d[k] = count_q[k] + CW'(1);
      if (!enq_vec[k] && deq_vec[k]) count_d[k] = count_q[k] - CW'(1);
    end
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_prior_d = out_prior_q;
    if (load_en) begin
      out_valid_d = any_ne;
      if (any_ne) begin
        out_data_d  = mem_q[pop_idx][rd_ptr_q[pop_idx]];
        out_prior_d = PRIOR_WIDTH'(pop_idx);
      end
    end
    drop_d = drop_q;
    bad_d  = bad_q;
    if (in_valid && legal && enq_full && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
    if (in_valid && !legal && (bad_q != '1)) bad_d = bad_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_Q; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_prior_q <= '0;
      drop_q      <= '0;
      bad_q       <= '0;
`ifdef PRIO_SCHED_STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_prior_q <= out_prior_d;
      drop_q      <= drop_d;
      bad_q       <= bad_d;
`ifdef PRIO_SCHED_STARVE_GUARD_EN
      starve_q    <= starve_d;
`endif
    end
  end

  // Storage needs no reset: the counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[in_idx][wr_ptr_q[in_idx]] <= in_data;
  end

  always_comb begin
    q_nonempty = '0;
    for (int k = 1; k < NUM_Q; k++) q_nonempty[k] = (count_q[k] != '0);
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_prior    = out_prior_q;
  assign drop_cnt     = drop_q;
  assign bad_prio_cnt = bad_q;

endmodule

// File: tb/tb_pkt_prio_sched.sv
// Bench for pkt_prio_sched: directed scenarios plus random traffic against a queue-based reference.
module tb_pkt_prio_sched;

  localparam int QD = 4;
  localparam int NQ = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [5:0]  in_prior = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [5:0]  out_prior;
  logic [7:0]  q_nonempty;
  logic [15:0] drop_cnt;
  logic [15:0] bad_prio_cnt;

  pkt_prio_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_prior(in_prior),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_prior(out_prior),
    .q_nonempty(q_nonempty), .drop_cnt(drop_cnt), .bad_prio_cnt(bad_prio_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: one word list per priority plus the egress register.
  logic [31:0] mq [NQ][$];
  logic        m_ov;
  logic [31:0] m_od;
  logic [5:0]  m_op;
  int          m_drop, m_bad, m_starve;

  logic [31:0] acc_d [$];
  logic [5:0]  acc_p [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic v, input logic [31:0] d, input logic [5:0] p,
                              input logic r, input logic rs);
    bit legal, full, load;
    int lo, hi, pick;
    if (!rs) begin
      for (int k = 0; k < NQ; k++) mq[k].delete();
      m_ov = 0; m_od = 0; m_op = 0; m_drop = 0; m_bad = 0; m_starve = 0;
      return;
    end
    legal = (p != 0) && (p < NQ);
    full  = legal && (mq[p].size() == QD);
    load  = !m_ov || r;
    if (load) begin
      lo = 0; hi = 0;
      for (int k = 1; k < NQ; k++) if (mq[k].size() > 0) begin
        if (lo == 0) lo = k;
        hi = k;
      end
      if (lo == 0) m_ov = 0;
      else begin
`ifdef PRIO_SCHED_STARVE_GUARD_EN
        pick = (m_starve >= 8) ? hi : lo;
        if (pick == hi) m_starve = 0; else m_starve++;
`else
        pick = lo;
`endif
        m_od = mq[pick].pop_front();
        m_op = 6'(pick);
        m_ov = 1;
      end
    end
    if (v) begin
      if (!legal) begin if (m_bad < 65535) m_bad++; end
      else if (full) begin if (m_drop < 65535) m_drop++; end
      else mq[p].push_back(d);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [5:0] p,
                      input logic r, input logic rs = 1'b1);
    logic [7:0] ne;
    in_valid = v; in_data = d; in_prior = p; out_ready = r; rst = rs;
    if (rs && out_valid === 1'b1 && r) begin
      acc_d.push_back(out_data);
      acc_p.push_back(out_prior);
    end
    @(posedge clk);
    model_update(v, d, p, r, rs);
    #1;
    ne = '0;
    for (int k = 1; k < NQ; k++) ne[k] = (mq[k].size() > 0);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", out_data, m_od);
    chk("out_prior", 32'(out_prior), 32'(m_op));
    chk("q_nonempty", 32'(q_nonempty), 32'(ne));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("bad_prio_cnt", 32'(bad_prio_cnt), 32'(m_bad));
  endtask

  task automatic do_reset();
    step(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int n6;
    // Reset and idle
    do_reset();
    repeat (3) step(1'b0, 32'h0, 6'd0, 1'b1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_nonempty", 32'(q_nonempty), 32'd0);
    chk("idle_drop", 32'(drop_cnt), 32'd0);
    chk("idle_bad", 32'(bad_prio_cnt), 32'd0);

    // Two-cycle latency with a single word
    step(1'b1, 32'hA5, 6'd3, 1'b1);
    chk("lat1_valid", 32'(out_valid), 32'd0);
    chk("lat1_nonempty", 32'(q_nonempty), 32'h08);
    step(1'b0, 32'h0, 6'd0, 1'b1);
    chk("lat2_valid", 32'(out_valid), 32'd1);
    chk("lat2_data", out_data, 32'hA5);
    chk("lat2_prior", 32'(out_prior), 32'd3);
    chk("lat2_nonempty", 32'(q_nonempty), 32'd0);
    step(1'b0, 32'h0, 6'd0, 1'b1);
    chk("lat3_valid", 32'(out_valid), 32'd0);

    // Backpressure holds the loaded word
    do_reset();
    step(1'b1, 32'h55, 6'd5, 1'b0);
    step(1'b1, 32'h22, 6'd2, 1'b0);
    repeat (3) step(1'b0, 32'h0, 6'd0, 1'b0);
    chk("hold_prior", 32'(out_prior), 32'd5);
    chk("hold_data", out_data, 32'h55);
    step(1'b0, 32'h0, 6'd0, 1'b1);
    chk("rel_prior", 32'(out_prior), 32'd2);
    chk("rel_data", out_data, 32'h22);
    step(1'b0, 32'h0, 6'd0, 1'b1);
    chk("rel_empty", 32'(out_valid), 32'd0);

    // Overflow and illegal priorities
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 32'h40 + 32'(i), 6'd4, 1'b0);
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    chk("ovf_nonempty", 32'(q_nonempty), 32'h10);
    step(1'b1, 32'h77, 6'd0, 1'b0);
    step(1'b1, 32'h78, 6'd8, 1'b0);
    chk("bad_cnt", 32'(bad_prio_cnt), 32'd2);
    repeat (6) step(1'b0, 32'h0, 6'd0, 1'b1);

    // Queue 1 kept busy while queue 6 waits
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h600 + 32'(i), 6'd6, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), 6'd1, 1'b0);
    acc_d.delete(); acc_p.delete();
    for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + 32'(i), 6'd1, 1'b1);
    chk("starve_first", (acc_p.size() > 0) ? 32'(acc_p[0]) : 32'hFFFF, 32'd6);
    n6 = 0;
    for (int i = 1; i < acc_p.size(); i++) if (acc_p[i] == 6'd6) n6++;
`ifdef PRIO_SCHED_STARVE_GUARD_EN
    chk("starve_q6_pops", 32'(n6), 32'd2);
`else
    chk("starve_q6_pops", 32'(n6), 32'd0);
`endif

    // Pointer wrap with toggling ready
    do_reset();
    acc_d.delete(); acc_p.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(i), 6'd2, 1'b1);
      step(1'b0, 32'h0, 6'd0, 1'b0);
    end
    repeat (6) step(1'b0, 32'h0, 6'd0, 1'b1);
    chk("wrap_count", 32'(acc_d.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      chk("wrap_order", (i < acc_d.size()) ? acc_d[i] : 32'hDEADBEEF, 32'(i));
    chk("wrap_drop", 32'(drop_cnt), 32'd0);

    // Reset mid-traffic discards queues 2 and 5
    do_reset();
    step(1'b1, 32'h1, 6'd2, 1'b0);
    step(1'b1, 32'h2, 6'd5, 1'b0);
    step(1'b1, 32'h3, 6'd5, 1'b0);
    step(1'b1, 32'h4, 6'd2, 1'b0);
    step(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    chk("mrst_nonempty", 32'(q_nonempty), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data", out_data, 32'd0);
    chk("mrst_prior", 32'(out_prior), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, r, rs;
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 299) != 0);
      step(v, $urandom, 6'($urandom_range(0, 9)), r, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
